// File: rtl/frame_slot_scheduler.sv
// Frame-slot scheduler: hands DDR frame-buffer slots to the frame writer and reader.
// Optional drop/repeat statistics counters are built when FRAME_SLOT_SCHED_STATS_EN is defined.
module frame_slot_scheduler #(
  parameter longint unsigned START_ADDR    = 0,
  parameter int unsigned     FRAMES_AMOUNT = 3,
  parameter int unsigned     FRAME_RES_X   = 1920,
  parameter int unsigned     FRAME_RES_Y   = 1080,
  parameter int unsigned     TDATA_WIDTH   = 16,
  parameter int unsigned     ADDR_WIDTH    = 32,
  localparam int unsigned    SLOT_W        = $clog2(FRAMES_AMOUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_req_i,
  input  logic                  wr_done_i,
  output logic                  wr_gnt_o,
  output logic [ADDR_WIDTH-1:0] wr_base_addr_o,
  output logic [SLOT_W-1:0]     wr_slot_o,
  input  logic                  rd_req_i,
  output logic                  rd_gnt_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH-1:0] rd_base_addr_o,
  output logic [SLOT_W-1:0]     rd_slot_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           repeat_cnt_o
);

  localparam int unsigned LOCAL_TDATA_WIDTH = (TDATA_WIDTH <= 8)  ? 8  :
                                              (TDATA_WIDTH <= 16) ? 16 :
                                              (TDATA_WIDTH <= 32) ? 32 : 64;
  localparam logic [63:0] SLOT_BYTES = 64'(FRAME_RES_X) * 64'(FRAME_RES_Y) *
                                       64'(LOCAL_TDATA_WIDTH / 8);
  localparam logic [63:0] END_ADDR   = 64'(START_ADDR) + 64'(FRAMES_AMOUNT) * SLOT_BYTES;
  localparam int unsigned CNT_W      = $clog2(FRAMES_AMOUNT + 1);

  // Elaboration-time parameter sanity checks
  if (FRAMES_AMOUNT < 3) begin : g_bad_frames
    $error("frame_slot_scheduler: FRAMES_AMOUNT must be at least 3");
  end
  if (ADDR_WIDTH < 64) begin : g_addr_chk
    if (END_ADDR > (64'(1) << ADDR_WIDTH)) begin : g_bad_addr
      $error("frame_slot_scheduler: frame slots exceed the address space");
    end
  end

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WRITING = 2'd1,
    SLOT_READY   = 2'd2,
    SLOT_READING = 2'd3
  } slot_state_e;

  logic [ADDR_WIDTH-1:0] base_tab [FRAMES_AMOUNT];

  for (genvar g = 0; g < FRAMES_AMOUNT; g++) begin : g_base
    assign base_tab[g] = ADDR_WIDTH'(64'(START_ADDR) + 64'(g) * SLOT_BYTES);
  end

  slot_state_e           state_q [FRAMES_AMOUNT];
  slot_state_e           state_n [FRAMES_AMOUNT];
  // READY list: entry 0 is the oldest completed frame, entry cnt-1 the newest
  logic [SLOT_W-1:0]     list_q  [FRAMES_AMOUNT];
  logic [SLOT_W-1:0]     list_n  [FRAMES_AMOUNT];
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_n;

  logic [SLOT_W-1:0]     wr_slot_n;
  logic [ADDR_WIDTH-1:0] wr_addr_n;
  logic [SLOT_W-1:0]     rd_slot_n;
  logic [ADDR_WIDTH-1:0] rd_addr_n;
  logic                  rd_valid_n;
  logic                  drop_evt;
  logic                  repeat_evt;

  logic                  w_found;
  logic [SLOT_W-1:0]     w_idx;
  logic                  r_found;
  logic [SLOT_W-1:0]     r_idx;
  logic                  f_found;
  logic [SLOT_W-1:0]     f_idx;
  logic [SLOT_W-1:0]     tail;
  logic [SLOT_W-1:0]     alloc;

  // Events applied in fixed order: completion, then read, then write allocation
  always_comb begin
    state_n    = state_q;
    list_n     = list_q;
    cnt_n      = cnt_q;
    wr_slot_n  = wr_slot_o;
    wr_addr_n  = wr_base_addr_o;
    rd_slot_n  = rd_slot_o;
    rd_addr_n  = rd_base_addr_o;
    rd_valid_n = rd_valid_o;
    drop_evt   = 1'b0;
    repeat_evt = 1'b0;
    w_found    = 1'b0;
    w_idx      = '0;
    r_found    = 1'b0;
    r_idx      = '0;
    f_found    = 1'b0;
    f_idx      = '0;
    tail       = '0;
    alloc      = '0;

    for (int i = 0; i < int'(FRAMES_AMOUNT); i++) begin
      if (!w_found && state_q[i] == SLOT_WRITING) begin
        w_found = 1'b1;
        w_idx   = SLOT_W'(i);
      end
      if (!r_found && state_q[i] == SLOT_READING) begin
        r_found = 1'b1;
        r_idx   = SLOT_W'(i);
      end
    end

    if (wr_done_i && w_found) begin
      state_n[w_idx]             = SLOT_READY;
      list_n[SLOT_W'(cnt_n)]     = w_idx;
      cnt_n                      = cnt_n + CNT_W'(1);
    end

    if (rd_req_i) begin
      if (cnt_n != '0) begin
        if (r_found) begin
          state_n[r_idx] = SLOT_FREE;
        end
        tail           = list_n[SLOT_W'(cnt_n - CNT_W'(1))];
        state_n[tail]  = SLOT_READING;
        cnt_n          = cnt_n - CNT_W'(1);
        rd_slot_n      = tail;
        rd_addr_n      = base_tab[tail];
        rd_valid_n     = 1'b1;
      end else if (r_found) begin
        repeat_evt = 1'b1;
        rd_slot_n  = r_idx;
        rd_addr_n  = base_tab[r_idx];
        rd_valid_n = 1'b1;
      end else begin
        rd_valid_n = 1'b0;
      end
    end

    if (wr_req_i) begin
      // A frame still being written is aborted and its slot recycled
      if (w_found && !wr_done_i) begin
        state_n[w_idx] = SLOT_FREE;
      end
      for (int i = int'(FRAMES_AMOUNT) - 1; i >= 0; i--) begin
        if (state_n[i] == SLOT_FREE) begin
          f_found = 1'b1;
          f_idx   = SLOT_W'(i);
        end
      end
      if (f_found) begin
        alloc = f_idx;
      end else begin
        alloc = list_n[0];
        for (int i = 0; i < int'(FRAMES_AMOUNT) - 1; i++) begin
          list_n[i] = list_n[i+1];
        end
        cnt_n    = cnt_n - CNT_W'(1);
        drop_evt = 1'b1;
      end
      state_n[alloc] = SLOT_WRITING;
      wr_slot_n      = alloc;
      wr_addr_n      = base_tab[alloc];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(FRAMES_AMOUNT); i++) begin
        state_q[i] <= SLOT_FREE;
        list_q[i]  <= '0;
      end
      cnt_q          <= '0;
      wr_gnt_o       <= 1'b0;
      rd_gnt_o       <= 1'b0;
      rd_valid_o     <= 1'b0;
      wr_slot_o      <= '0;
      rd_slot_o      <= '0;
      wr_base_addr_o <= ADDR_WIDTH'(START_ADDR);
      rd_base_addr_o <= ADDR_WIDTH'(START_ADDR);
    end else begin
      state_q        <= state_n;
      list_q         <= list_n;
      cnt_q          <= cnt_n;
      wr_gnt_o       <= wr_req_i;
      rd_gnt_o       <= rd_req_i;
      rd_valid_o     <= rd_valid_n;
      wr_slot_o      <= wr_slot_n;
      rd_slot_o      <= rd_slot_n;
      wr_base_addr_o <= wr_addr_n;
      rd_base_addr_o <= rd_addr_n;
    end
  end

`ifdef FRAME_SLOT_SCHED_STATS_EN
  // Saturating drop / repeat statistics
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      drop_cnt_o   <= '0;
      repeat_cnt_o <= '0;
    end else begin
      if (drop_evt && drop_cnt_o != 16'hFFFF) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
      if (repeat_evt && repeat_cnt_o != 16'hFFFF) begin
        repeat_cnt_o <= repeat_cnt_o + 16'd1;
      end
    end
  end
`else
  logic unused_evt;
  assign unused_evt   = drop_evt ^ repeat_evt;
  assign drop_cnt_o   = '0;
  assign repeat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_frame_slot_scheduler.sv
// Bench for frame_slot_scheduler: directed vector table, async-reset sequence,
// and a randomized stream checked against a queue-based slot model.
module tb_frame_slot_scheduler;

  localparam int unsigned N          = 3;
  localparam logic [31:0] START      = 32'h0;
  localparam logic [31:0] FRAME_B    = 32'd4147200;

  logic        clk_i;
  logic        rst_i;
  logic        wr_req_i;
  logic        wr_done_i;
  logic        wr_gnt_o;
  logic [31:0] wr_base_addr_o;
  logic [1:0]  wr_slot_o;
  logic        rd_req_i;
  logic        rd_gnt_o;
  logic        rd_valid_o;
  logic [31:0] rd_base_addr_o;
  logic [1:0]  rd_slot_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] repeat_cnt_o;

  frame_slot_scheduler #(
    .START_ADDR    (0),
    .FRAMES_AMOUNT (3),
    .FRAME_RES_X   (1920),
    .FRAME_RES_Y   (1080),
    .TDATA_WIDTH   (16),
    .ADDR_WIDTH    (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_req_i       (wr_req_i),
    .wr_done_i      (wr_done_i),
    .wr_gnt_o       (wr_gnt_o),
    .wr_base_addr_o (wr_base_addr_o),
    .wr_slot_o      (wr_slot_o),
    .rd_req_i       (rd_req_i),
    .rd_gnt_o       (rd_gnt_o),
    .rd_valid_o     (rd_valid_o),
    .rd_base_addr_o (rd_base_addr_o),
    .rd_slot_o      (rd_slot_o),
    .drop_cnt_o     (drop_cnt_o),
    .repeat_cnt_o   (repeat_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct packed {
    logic        wr_gnt;
    logic [1:0]  wr_slot;
    logic [31:0] wr_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [1:0]  rd_slot;
    logic [31:0] rd_addr;
    logic [15:0] drop;
    logic [15:0] rep;
  } out_t;

  typedef struct {
    bit wq; bit wd; bit rr;
    int wg; int ws; int rg; int rv; int rs; int drop; int rep;
  } vec_t;

  out_t dut_out;
  assign dut_out = {wr_gnt_o, wr_slot_o, wr_base_addr_o, rd_gnt_o, rd_valid_o,
                    rd_slot_o, rd_base_addr_o, drop_cnt_o, repeat_cnt_o};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] addr_of(input int s);
    return START + 32'(s) * FRAME_B;
  endfunction

  function automatic logic [15:0] cnt_view(input int v);
`ifdef FRAME_SLOT_SCHED_STATS_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  function automatic out_t reset_out();
    out_t o;
    o = '0;
    o.wr_addr = START;
    o.rd_addr = START;
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: who writes, who reads, and the age-ordered READY queue
  int   m_wr;
  int   m_rd;
  int   m_q[$];
  int   m_drop;
  int   m_rep;
  out_t m_out;

  task automatic model_reset();
    m_wr = -1;
    m_rd = -1;
    m_q.delete();
    m_drop = 0;
    m_rep  = 0;
    m_out  = reset_out();
  endtask

  function automatic bit in_q(input int s);
    foreach (m_q[k]) if (m_q[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit wq, input bit wd, input bit rr);
    int s;
    m_out.wr_gnt = wq;
    m_out.rd_gnt = rr;
    if (wd && m_wr >= 0) begin
      m_q.push_back(m_wr);
      m_wr = -1;
    end
    if (rr) begin
      if (m_q.size() > 0) begin
        m_rd = m_q.pop_back();
        m_out.rd_valid = 1'b1;
        m_out.rd_slot  = 2'(m_rd);
        m_out.rd_addr  = addr_of(m_rd);
      end else if (m_rd >= 0) begin
        if (m_rep < 65535) m_rep++;
      end else begin
        m_out.rd_valid = 1'b0;
      end
    end
    if (wq) begin
      m_wr = -1;
      s = -1;
      for (int i = 0; i < int'(N); i++)
        if (s < 0 && i != m_rd && !in_q(i)) s = i;
      if (s < 0) begin
        s = m_q.pop_front();
        if (m_drop < 65535) m_drop++;
      end
      m_wr = s;
      m_out.wr_slot = 2'(s);
      m_out.wr_addr = addr_of(s);
    end
    m_out.drop = cnt_view(m_drop);
    m_out.rep  = cnt_view(m_rep);
  endtask

  // Called at posedge+1; drives one cycle of requests and samples at the next posedge+1
  task automatic apply(input bit wq, input bit wd, input bit rr);
    wr_req_i  = wq;
    wr_done_i = wd;
    rd_req_i  = rr;
    @(posedge clk_i);
    #1;
    wr_req_i  = 1'b0;
    wr_done_i = 1'b0;
    rd_req_i  = 1'b0;
    model_step(wq, wd, rr);
  endtask

  function automatic out_t vec_out(input vec_t v);
    out_t o;
    o.wr_gnt   = 1'(v.wg);
    o.wr_slot  = 2'(v.ws);
    o.wr_addr  = addr_of(v.ws);
    o.rd_gnt   = 1'(v.rg);
    o.rd_valid = 1'(v.rv);
    o.rd_slot  = 2'(v.rs);
    o.rd_addr  = addr_of(v.rs);
    o.drop     = cnt_view(v.drop);
    o.rep      = cnt_view(v.rep);
    return o;
  endfunction

  vec_t vecs[$];
  out_t exp_o;
  bit   rq_w, rq_d, rq_r;

  initial begin
    rst_i     = 1'b0;
    wr_req_i  = 1'b0;
    wr_done_i = 1'b0;
    rd_req_i  = 1'b0;
    model_reset();

    //           wq wd rr  wg ws rg rv rs drop rep
    vecs.push_back('{0, 0, 1,  0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0,  1, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1,  0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 0,  0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0,  1, 2, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 0,  0, 2, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0,  1, 1, 0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 1,  0, 1, 1, 1, 2, 1, 0});
    vecs.push_back('{0, 0, 1,  0, 1, 1, 1, 2, 1, 1});
    vecs.push_back('{0, 1, 1,  0, 1, 1, 1, 1, 1, 1});
    vecs.push_back('{1, 0, 1,  1, 0, 1, 1, 1, 1, 2});
    vecs.push_back('{1, 0, 0,  1, 0, 0, 1, 1, 1, 2});
    vecs.push_back('{1, 1, 0,  1, 2, 0, 1, 1, 1, 2});
    vecs.push_back('{0, 0, 1,  0, 2, 1, 1, 0, 1, 2});
    vecs.push_back('{0, 0, 0,  0, 2, 0, 1, 0, 1, 2});

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_state", dut_out, reset_out());
    rst_i = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k].wq, vecs[k].wd, vecs[k].rr);
      check($sformatf("vec%0d", k), dut_out, vec_out(vecs[k]));
    end

    // Asynchronous reset in the middle of a cycle, with slots owned
    apply(1, 0, 0);
    apply(0, 1, 1);
    #3;
    rst_i = 1'b0;
    #1;
    check("async_reset", dut_out, reset_out());
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    apply(1, 0, 1);
    exp_o = reset_out();
    exp_o.wr_gnt = 1'b1;
    exp_o.rd_gnt = 1'b1;
    check("post_reset_grant", dut_out, exp_o);
    apply(0, 1, 0);
    apply(0, 0, 1);
    exp_o.wr_gnt   = 1'b0;
    exp_o.rd_valid = 1'b1;
    check("post_reset_read", dut_out, exp_o);
    apply(0, 0, 1);
    exp_o.rep = cnt_view(1);
    check("post_reset_repeat", dut_out, exp_o);
    check("model_sync", dut_out, m_out);

    // Randomised request stream against the model
    for (int c = 0; c < 10000; c++) begin
      rq_w = ($urandom_range(0, 5) == 0);
      rq_d = ($urandom_range(0, 4) == 0);
      rq_r = ($urandom_range(0, 4) == 0);
      apply(rq_w, rq_d, rq_r);
      check($sformatf("rand%0d", c), dut_out, m_out);
      if (m_wr >= 0 && m_rd >= 0) begin
        n_tests++;
        if (wr_slot_o == rd_slot_o) begin
          n_fail++;
          $display("FAIL slot_overlap cycle %0d: wr_slot %0d equals rd_slot %0d, required distinct",
                   c, wr_slot_o, rd_slot_o);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_slot_scheduler.md
# frame_slot_scheduler

Single-clock frame-slot scheduler for the DDR frame buffer. It owns the FRAMES_AMOUNT frame slots in memory and hands base addresses to the frame write controller and frame read controller. The writer never stalls: when no slot is free, the oldest completed frame is dropped. The reader always gets the newest completed frame, or repeats the last one if no newer frame exists. Strobe CDC sits outside this block; all request and done inputs arrive already in clk_i.

## Interface
- START_ADDR, 0: byte address of slot 0.
- FRAMES_AMOUNT, 3: number of slots; must be ≥3 (elaboration error otherwise).
- FRAME_RES_X, 1920: pixels per line.
- FRAME_RES_Y, 1080: lines per frame.
- TDATA_WIDTH, 16: pixel width in bits; rounded up to 8/16/32/64 (LOCAL width) for slot sizing.
- ADDR_WIDTH, 32: address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- wr_req_i  in  1  writer wants a slot (pulse at frame start).
- wr_done_i  in  1  writer finished its current frame (pulse).
- wr_gnt_o  out  1  one-cycle grant for wr_req_i.
- wr_base_addr_o  out  ADDR_WIDTH  base address of the writer slot.
- wr_slot_o  out  $clog2(FRAMES_AMOUNT)  writer slot index.
- rd_req_i  in  1  reader wants a frame (pulse at frame start).
- rd_gnt_o  out  1  one-cycle grant for rd_req_i.
- rd_valid_o  out  1  a readable slot is assigned to the reader.
- rd_base_addr_o  out  ADDR_WIDTH  base address of the reader slot.
- rd_slot_o  out  $clog2(FRAMES_AMOUNT)  reader slot index.
- drop_cnt_o  out  16  frames dropped (stats build only).
- repeat_cnt_o  out  16  frames repeated (stats build only).

## Operation
- Each slot is in one of four states: FREE, WRITING, READY, READING. At most one slot is WRITING and at most one is READING.
- READY slots are kept in an ordered list of depth FRAMES_AMOUNT. The head is the oldest completed frame; the tail is the newest.
- Slot base address = START_ADDR + slot × FRAME_RES_X × FRAME_RES_Y × LOCAL_TDATA_WIDTH/8.
  - The product is computed at elaboration in 64 bits.
  - An elaboration error is raised if the last slot's end address exceeds 2^ADDR_WIDTH.
- wr_done_i:
  - If a WRITING slot exists, it becomes READY and is appended at the tail.
  - Otherwise the pulse is ignored.
- rd_req_i:
  - The READING slot (if any) is released first. It returns to FREE if the READY list is non-empty; otherwise it stays READING and is re-granted as a repeat (repeat_cnt +1).
  - If the READY list is non-empty, the tail slot becomes READING. Any older READY slots stay READY.
  - rd_valid_o is 0 only when no frame has ever completed.
- wr_req_i:
  - A WRITING slot (aborted frame) returns to FREE.
  - Allocation picks the lowest-index FREE slot. If none is FREE, the head of the READY list is removed and reused (drop_cnt +1).
  - Because FRAMES_AMOUNT ≥ 3, allocation always succeeds.
- Same-cycle events are processed in the fixed order wr_done_i → rd_req_i → wr_req_i. Consequences:
  - A frame completing in the same cycle as rd_req_i is visible to that read.
  - The reader claims its slot before the writer allocates.
- Counters saturate at 0xFFFF and reset to 0.

## Timing
- Grants are registered: wr_gnt_o and rd_gnt_o pulse exactly 1 cycle after the request.
- Address, slot and rd_valid_o outputs update in the same cycle as their grant and hold until the next grant.
- A request asserted on consecutive cycles is treated as two requests; each is granted.
- Slot state and the READY list update on the request/done cycle. The next cycle's event sees the new state.
- Reset values:
  - All slots FREE; READY list empty.
  - wr_gnt_o = rd_gnt_o = rd_valid_o = 0.
  - wr_slot_o = rd_slot_o = 0.
  - Both base addresses = START_ADDR.
  - Counters = 0.
- Reset asserted mid-operation discards all slot ownership immediately (asynchronous). The first grant after release follows the reset state.

## Configuration
- FRAME_SLOT_SCHED_STATS_EN defined: drop_cnt_o and repeat_cnt_o are implemented as 16-bit saturating counters.
- Not defined: both outputs are tied to 0 and the counter logic is not built. Scheduling behaviour is identical in both builds.

## Test plan
- Reset, then rd_req_i → rd_gnt_o 1 cycle later with rd_valid_o=0. Then wr_req_i → slot 0, wr_base_addr_o=START_ADDR.
- Defaults, 16-bit pixels: wr_req, wr_done, wr_req → second grant is slot 1 at START_ADDR+4147200. rd_req → rd_slot_o=0, rd_valid_o=1.
- Reader holds slot 0, writer completes slots 1 and 2, then wr_req → slot 1 reused (oldest READY). drop_cnt_o=1 in the stats build, 0 otherwise.
- rd_req with no new frame since the last read → same rd_slot_o re-granted, repeat_cnt_o increments.
- wr_done_i and rd_req_i in the same cycle → reader receives the just-completed slot.
- Randomised request stream over 10k cycles → the WRITING slot never equals the READING slot, and grants always arrive 1 cycle after each request.
